// File: rtl/cpu_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem read at a
// time, buffers returned words in a small FIFO and applies control redirects.
module cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jb_taken,
  input  logic        jb_abs,
  input  logic [31:0] jb_base_pc,
  input  logic [31:0] jb_imm,
  output logic        fetch_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_pc;
  logic [31:0]   r_addr;
  logic          r_req;
  logic          r_fetch_err;

  logic [31:0]   r_buf_instr [DEPTH];
  logic [31:0]   r_buf_pc    [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_target_raw;
  logic [31:0]   w_target;
  logic          w_misaligned;

  function automatic logic [31:0] redirect_target(
    input logic        abs_sel,
    input logic [31:0] base,
    input logic [31:0] imm
  );
    logic signed [31:0] sum;
    sum = $signed(base) + $signed(imm);
    return abs_sel ? imm : $unsigned(sum);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign w_target_raw = redirect_target(jb_abs, jb_base_pc, jb_imm);
  assign w_target     = word_align(w_target_raw);
  assign w_misaligned = (w_target_raw[1:0] != 2'b00);

  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid && instr_ready;

  // Next state and handshake decode; a redirect always empties the buffer,
  // and data returning for a wrong-path request is never pushed.
  always_comb begin
    w_state_nxt = r_state;
    w_rsp       = r_req && imem_rvalid;
    w_push      = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE:  w_state_nxt = FETCH;
      FETCH: begin
        w_push = w_rsp && !jb_taken;
        if (jb_taken && r_req && !imem_rvalid) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_rsp) begin
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_count_nxt = jb_taken ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    w_issue     = (r_state == FETCH) && !halt && !r_req && (w_count_nxt < DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_req       <= 1'b0;
      r_fetch_err <= 1'b0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_fetch_err <= jb_taken && w_misaligned;

      if (jb_taken) begin
        r_pc <= w_target;
      end else if (w_push) begin
        r_pc <= r_pc + 32'd4;
      end

      // Request is held with a stable address until rvalid is seen; a fresh
      // redirect with nothing outstanding goes straight to the target.
      if (w_issue) begin
        r_req  <= 1'b1;
        r_addr <= jb_taken ? w_target : r_pc;
      end else if (w_rsp) begin
        r_req <= 1'b0;
      end

      r_count <= w_count_nxt;
      if (jb_taken) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= imem_rdata;
      r_buf_pc[r_wr_ptr]    <= r_addr;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign fetch_err = r_fetch_err;
  assign instr     = instr_valid ? r_buf_instr[r_rd_ptr] : 32'd0;
  assign instr_pc  = instr_valid ? r_buf_pc[r_rd_ptr]    : 32'd0;

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: variable-latency memory model returning
// ~addr, an expected-PC scoreboard and a request-hold monitor.
module tb_cpu_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jb_taken;
  logic        jb_abs;
  logic [31:0] jb_base_pc;
  logic [31:0] jb_imm;
  logic        fetch_err;

  cpu_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jb_taken(jb_taken), .jb_abs(jb_abs),
    .jb_base_pc(jb_base_pc), .jb_imm(jb_imm), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int mem_lat  = 1;
  int wait_cnt = 0;
  assign imem_rvalid = imem_req && (wait_cnt >= mem_lat - 1);
  assign imem_rdata  = ~imem_addr;
  always @(posedge clk) begin
    if (!imem_req || imem_rvalid) wait_cnt <= 0;
    else                          wait_cnt <= wait_cnt + 1;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_del   = 0;
  int          n0;
  logic [31:0] exp_q[$];
  logic [31:0] issue_q[$];
  logic [31:0] old_addr;
  logic        prev_req = 1'b0;
  logic        prev_rv  = 1'b0;
  logic [31:0] prev_addr = '0;
  int          cur_len  = 0;
  int          last_len = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_outstanding(input logic want_rv);
    bit ok = 1'b0;
    int n  = 0;
    while (!ok && n < 40) begin
      if (imem_req && (imem_rvalid == want_rv)) ok = 1'b1;
      else begin tick(); n++; end
    end
    check_eq("wait_req", 32'(ok), 32'd1);
  endtask

  task automatic wait_issue(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (issue_q.size() == 0 && n < 40) begin tick(); n++; end
    check_eq({tag, "_issued"}, 32'(issue_q.size() != 0), 32'd1);
    if (issue_q.size() != 0) check_eq(tag, issue_q[0], exp_addr);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req"},   32'(imem_req), 32'd0);
    check_eq({tag, "_addr"},  imem_addr, RST_PC);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_instr"}, instr, 32'd0);
    check_eq({tag, "_ipc"},   instr_pc, 32'd0);
    check_eq({tag, "_err"},   32'(fetch_err), 32'd0);
  endtask

  // Scoreboard and request-protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req <= 1'b0;
      prev_rv  <= 1'b0;
      cur_len  <= 0;
    end else begin
      if (prev_req && !prev_rv) begin
        check_eq("req_hold", 32'(imem_req), 32'd1);
        check_eq("addr_hold", imem_addr, prev_addr);
      end
      if (imem_req && !prev_req) issue_q.push_back(imem_addr);
      if (imem_req && imem_rvalid) begin
        last_len <= cur_len + 1;
        cur_len  <= 0;
      end else if (imem_req) begin
        cur_len <= cur_len + 1;
      end
      prev_req  <= imem_req;
      prev_rv   <= imem_rvalid;
      prev_addr <= imem_addr;
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          check_eq("sb_pc", instr_pc, exp_q[0]);
          check_eq("sb_data", instr, ~exp_q[0]);
          void'(exp_q.pop_front());
          n_del++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; halt = 1'b0; instr_ready = 1'b1;
    jb_taken = 1'b0; jb_abs = 1'b0; jb_base_pc = '0; jb_imm = '0;
    repeat (3) tick();
    check_reset("rst");

    // Zero-wait memory: request at N, instr_valid at N+1.
    expect_stream(RST_PC);
    rst_n = 1'b1;
    tick();
    check_eq("idle_req", 32'(imem_req), 32'd0);
    tick();
    check_eq("first_req", 32'(imem_req), 32'd1);
    check_eq("first_addr", imem_addr, RST_PC);
    tick();
    check_eq("first_valid", 32'(instr_valid), 32'd1);
    check_eq("first_pc", instr_pc, RST_PC);
    repeat (12) tick();
    check_eq("stream_delivered", 32'(n_del >= 3), 32'd1);

    // Back-pressure: buffer fills, no further requests.
    instr_ready = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("full_no_req", 32'(imem_req), 32'd0);
      check_eq("full_valid", 32'(instr_valid), 32'd1);
      check_eq("full_head", instr_pc, exp_q[0]);
      tick();
    end
    n0 = n_del;
    instr_ready = 1'b1;
    repeat (16) tick();
    check_eq("bp_resume", 32'(n_del - n0 >= 4), 32'd1);

    // Three-cycle memory.
    mem_lat = 3;
    repeat (20) tick();
    check_eq("lat3_hold", 32'(last_len), 32'd3);

    // Relative redirect while a request is outstanding.
    wait_outstanding(1'b0);
    old_addr = imem_addr;
    jb_taken = 1'b1; jb_abs = 1'b0; jb_base_pc = 32'h200; jb_imm = 32'hFFFF_FFF0;
    tick();
    jb_taken = 1'b0;
    expect_stream(32'h1F0);
    issue_q.delete();
    check_eq("rel_flush", 32'(instr_valid), 32'd0);
    check_eq("rel_drain_req", 32'(imem_req), 32'd1);
    check_eq("rel_drain_addr", imem_addr, old_addr);
    check_eq("rel_no_err", 32'(fetch_err), 32'd0);
    wait_issue("rel_target", 32'h1F0);
    check_eq("rel_no_stale", 32'(instr_valid), 32'd0);
    n0 = n_del;
    repeat (20) tick();
    check_eq("rel_delivered", 32'(n_del - n0 >= 2), 32'd1);

    // Absolute, misaligned redirect.
    wait_outstanding(1'b0);
    jb_taken = 1'b1; jb_abs = 1'b1; jb_imm = 32'h302;
    tick();
    jb_taken = 1'b0;
    expect_stream(32'h300);
    issue_q.delete();
    check_eq("abs_err_pulse", 32'(fetch_err), 32'd1);
    check_eq("abs_flush", 32'(instr_valid), 32'd0);
    tick();
    check_eq("abs_err_clear", 32'(fetch_err), 32'd0);
    wait_issue("abs_target", 32'h300);
    repeat (16) tick();

    // Redirect coincident with rvalid: data dropped, no drain.
    wait_outstanding(1'b1);
    jb_taken = 1'b1; jb_abs = 1'b1; jb_imm = 32'h400;
    tick();
    jb_taken = 1'b0;
    expect_stream(32'h400);
    check_eq("coin_req_drop", 32'(imem_req), 32'd0);
    check_eq("coin_flush", 32'(instr_valid), 32'd0);
    tick();
    check_eq("coin_req", 32'(imem_req), 32'd1);
    check_eq("coin_addr", imem_addr, 32'h400);
    n0 = n_del;
    repeat (20) tick();
    check_eq("coin_delivered", 32'(n_del - n0 >= 2), 32'd1);

    // Halt mid-stream, then asynchronous reset during a request.
    mem_lat = 1;
    repeat (10) tick();
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("halt_no_req", 32'(imem_req), 32'd0);
    end
    check_eq("halt_drained", 32'(instr_valid), 32'd0);
    halt = 1'b0;
    tick();
    check_eq("halt_resume", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    tick();
    expect_stream(RST_PC);
    rst_n = 1'b1;
    n0 = n_del;
    repeat (12) tick();
    check_eq("restart_delivered", 32'(n_del - n0 >= 2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
